// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: PC, request/ready imem port and IF/ID register.
// Optional feature: define IF_PERF_CNT_EN to add the saturating bubble_cnt output.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  hazard,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [31:0] branch_address,
    input  logic [31:0] jump_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        fetch_stall
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]      state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] hold_instr, hold_instr_n;
    logic [XLEN-1:0] redir_pc, redir_pc_n;
    logic [XLEN-1:0] instr_n, ifpc_n;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;
    logic            redirect, pc_we, ifid_we, load_nop;

    // select_cancel is consumed elsewhere in the pipeline
    logic unused_hazard;
    assign unused_hazard = hazard[0];

    assign redirect = branch_taken | jump;
    assign target   = jump ? jump_address : branch_address;
    assign pc_we    = hazard[1];
    assign ifid_we  = hazard[2];
    assign pc_plus4 = XLEN'(pc + 32'd4);

    // Request is suppressed during reset so the port is quiet until release
    assign imem_req    = ~rst & (state != ST_HOLD);
    assign imem_addr   = pc;
    assign fetch_stall = imem_req & ~imem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            hold_instr <= '0;
            redir_pc   <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_instr <= hold_instr_n;
            redir_pc   <= redir_pc_n;
            ifid_instr <= instr_n;
            ifid_pc    <= ifpc_n;
        end
    end

    // Next-state and register-update decode
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        hold_instr_n = hold_instr;
        redir_pc_n   = redir_pc;
        instr_n      = ifid_instr;
        ifpc_n       = ifid_pc;
        load_nop     = 1'b0;

        case (state)
            ST_FETCH: begin
                if (redirect) begin
                    load_nop = 1'b1;
                    if (imem_ready) begin
                        pc_n = target;
                    end else begin
                        redir_pc_n = target;
                        state_n    = ST_DROP;
                    end
                end else if (imem_ready && pc_we && ifid_we) begin
                    instr_n = imem_rdata;
                    ifpc_n  = pc_plus4;
                    pc_n    = pc_plus4;
                end else if (imem_ready) begin
                    hold_instr_n = imem_rdata;
                    state_n      = ST_HOLD;
                end else if (ifid_we) begin
                    load_nop = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    load_nop = 1'b1;
                    pc_n     = target;
                    state_n  = ST_FETCH;
                end else if (pc_we && ifid_we) begin
                    instr_n = hold_instr;
                    ifpc_n  = pc_plus4;
                    pc_n    = pc_plus4;
                    state_n = ST_FETCH;
                end
            end
            ST_DROP: begin
                // Latest redirect target wins; the returning word is discarded
                if (redirect) begin
                    redir_pc_n = target;
                end
                if (redirect || ifid_we) begin
                    load_nop = 1'b1;
                end
                if (imem_ready) begin
                    pc_n    = redirect ? target : redir_pc;
                    state_n = ST_FETCH;
                end
            end
            default: begin
                state_n = ST_FETCH;
            end
        endcase

        if (load_nop) begin
            instr_n = NOP_INSTR;
            ifpc_n  = '0;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Saturating count of NOPs written into IF/ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (load_nop && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule
